// File: rtl/io_regs_pkg.sv
// io_regs_pkg: shared register-bus widths, register indices and the index decoder
// used by io_register_block.
package io_regs_pkg;

    localparam int REG_INDEX_WIDTH = 7;
    localparam int REG_DATA_WIDTH  = 16;
    localparam int SEG_WIDTH       = 7;

    localparam logic [REG_INDEX_WIDTH-1:0] REG_LED        = 7'h01;
    localparam logic [REG_INDEX_WIDTH-1:0] REG_DIGIT_BASE = 7'h02;
    localparam logic [REG_INDEX_WIDTH-1:0] REG_BTN_LEVEL  = 7'h10;
    localparam logic [REG_INDEX_WIDTH-1:0] REG_BTN_PRESS  = 7'h11;
    localparam logic [REG_INDEX_WIDTH-1:0] REG_TIMER      = 7'h12;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LED,
        SEL_DIGIT,
        SEL_BTN_LEVEL,
        SEL_BTN_PRESS,
        SEL_TIMER
    } reg_sel_e;

    // Digit registers occupy a window whose length depends on the instance.
    function automatic reg_sel_e reg_decode(input logic [REG_INDEX_WIDTH-1:0] idx,
                                            input int num_digits);
        if (idx == REG_LED)
            return SEL_LED;
        if (int'(idx) >= int'(REG_DIGIT_BASE) && int'(idx) < int'(REG_DIGIT_BASE) + num_digits)
            return SEL_DIGIT;
        if (idx == REG_BTN_LEVEL)
            return SEL_BTN_LEVEL;
        if (idx == REG_BTN_PRESS)
            return SEL_BTN_PRESS;
        if (idx == REG_TIMER)
            return SEL_TIMER;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/io_register_block_button_sync.sv
// button_sync: two-flop synchroniser for asynchronous button levels plus a third
// flop giving a one-cycle rising-edge press pulse.
module button_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_press
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_press = r_sync & ~r_prev;

endmodule

// File: rtl/io_register_block.sv
// io_register_block: LED, seven-segment digit and push-button registers on the
// lisp_core register bus; the prescaled timer exists only with IO_REGISTER_TIMER_EN.
module io_register_block
    import io_regs_pkg::*;
#(
    parameter int LED_WIDTH   = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_BUTTONS = 4,
    parameter int PRESCALE    = 50000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [REG_INDEX_WIDTH-1:0]    register_index,
    input  logic                          register_read,
    input  logic                          register_write,
    input  logic [REG_DATA_WIDTH-1:0]     register_write_value,
    output logic [REG_DATA_WIDTH-1:0]     register_read_value,
    input  logic [NUM_BUTTONS-1:0]        buttons,
    output logic [LED_WIDTH-1:0]          led,
    output logic [SEG_WIDTH*NUM_DIGITS-1:0] digits
);

    reg_sel_e                   w_sel;
    logic [2:0]                 w_digit_k;
    logic [NUM_BUTTONS-1:0]     w_level;
    logic [NUM_BUTTONS-1:0]     w_press;
    logic [NUM_BUTTONS-1:0]     w_press_clr;
    logic [REG_DATA_WIDTH-1:0]  w_rdata;
    logic                       w_unused;

    logic [LED_WIDTH-1:0]       r_led;
    logic [SEG_WIDTH-1:0]       r_seg [NUM_DIGITS];
    logic [NUM_BUTTONS-1:0]     r_press;
    logic [REG_DATA_WIDTH-1:0]  r_read_value;

    assign w_sel     = reg_decode(register_index, NUM_DIGITS);
    assign w_digit_k = register_index[2:0] - 3'(REG_DIGIT_BASE);
    assign w_unused  = ^register_write_value;

    button_sync #(
        .WIDTH(NUM_BUTTONS)
    ) u_button_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .i_async(buttons),
        .o_level(w_level),
        .o_press(w_press)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_led <= '0;
        else if (register_write && w_sel == SEL_LED)
            r_led <= register_write_value[LED_WIDTH-1:0];
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                r_seg[g] <= '0;
            else if (register_write && w_sel == SEL_DIGIT && w_digit_k == 3'(g))
                r_seg[g] <= register_write_value[SEG_WIDTH-1:0];
        end
        assign digits[SEG_WIDTH*g +: SEG_WIDTH] = r_seg[g];
    end

    // A new press event is OR-ed in after clearing, so it survives a same-cycle clear.
    assign w_press_clr = {NUM_BUTTONS{register_read && w_sel == SEL_BTN_PRESS}}
                       | ({NUM_BUTTONS{register_write && w_sel == SEL_BTN_PRESS}}
                          & register_write_value[NUM_BUTTONS-1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_press <= '0;
        else
            r_press <= (r_press & ~w_press_clr) | w_press;
    end

`ifdef IO_REGISTER_TIMER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]             r_prescale;
    logic [REG_DATA_WIDTH-1:0] r_timer;
    logic                      w_wrap;

    assign w_wrap = (r_prescale == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale <= '0;
            r_timer    <= '0;
        end else if (register_write && w_sel == SEL_TIMER) begin
            r_prescale <= '0;
            r_timer    <= register_write_value;
        end else begin
            r_prescale <= w_wrap ? '0 : r_prescale + PW'(1);
            r_timer    <= w_wrap ? r_timer + 16'd1 : r_timer;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (w_sel == SEL_LED)
            w_rdata[LED_WIDTH-1:0] = r_led;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (w_sel == SEL_DIGIT && w_digit_k == 3'(k))
                w_rdata[SEG_WIDTH-1:0] = r_seg[k];
        if (w_sel == SEL_BTN_LEVEL)
            w_rdata[NUM_BUTTONS-1:0] = w_level;
        if (w_sel == SEL_BTN_PRESS)
            w_rdata[NUM_BUTTONS-1:0] = r_press;
`ifdef IO_REGISTER_TIMER_EN
        if (w_sel == SEL_TIMER)
            w_rdata = r_timer;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_read_value <= '0;
        else if (register_read)
            r_read_value <= w_rdata;
    end

    assign register_read_value = r_read_value;
    assign led                 = r_led;

endmodule
